// File: rtl/mini_src_control_unit_if.sv
// Control bus between the Mini SRC control sequencer and its datapath.
// master: the control unit (consumes stop/ir/con_ff, drives every strobe).
// slave:  the datapath side (drives stop/ir/con_ff, consumes every strobe).
//   stop        halt request, honoured only at an instruction boundary
//   ir          instruction register, opcode in ir[31:27]
//   con_ff      branch condition flip-flop
//   *out        bus drive selects      *en   register load enables
//   Read/Write  memory strobes         Gra..incPC  select/encode and branch controls
//   alu_control ALU operation code     run   high while executing
//   step        current state code (debug)
interface mini_src_control_unit_if;
  logic        stop;
  logic [31:0] ir;
  logic        con_ff;

  logic PCout, ZHIout, ZLOout, MDRout, HIout, LOout, Cout;
  logic PCen, IRen, MARen, MDRen, Yen, ZHIen, ZLOen, HIen, LOen;
  logic Read, Write;
  logic Gra, Grb, Grc, Rin, Rout, BAout, ConIn, incPC;
  logic [4:0] alu_control;
  logic       run;
  logic [3:0] step;

  modport master (
    input  stop, ir, con_ff,
    output PCout, ZHIout, ZLOout, MDRout, HIout, LOout, Cout,
    output PCen, IRen, MARen, MDRen, Yen, ZHIen, ZLOen, HIen, LOen,
    output Read, Write,
    output Gra, Grb, Grc, Rin, Rout, BAout, ConIn, incPC,
    output alu_control, run, step
  );

  modport slave (
    output stop, ir, con_ff,
    input  PCout, ZHIout, ZLOout, MDRout, HIout, LOout, Cout,
    input  PCen, IRen, MARen, MDRen, Yen, ZHIen, ZLOen, HIen, LOen,
    input  Read, Write,
    input  Gra, Grb, Grc, Rin, Rout, BAout, ConIn, incPC,
    input  alu_control, run, step
  );
endinterface

// File: rtl/mini_src_control_unit.sv
// Hardwired Moore control sequencer for the Mini SRC datapath.
// Fetch runs T0-T2, then per-opcode execute steps T3-T7; outputs decode from the
// registered state plus ir[31:27] (and con_ff in the branch T6 step).
// Ports:
//   clk  rising-edge clock
//   clr  asynchronous active-high reset, forces RESET with all outputs low
//   bus  control bus (master side), see mini_src_control_unit_if
// step codes: RESET=0, T0..T7=1..8, HALT=15.
module mini_src_control_unit (
  input logic                           clk,
  input logic                           clr,
  mini_src_control_unit_if.master       bus
);

  typedef enum logic [3:0] {
    StReset = 4'd0,
    StT0    = 4'd1,
    StT1    = 4'd2,
    StT2    = 4'd3,
    StT3    = 4'd4,
    StT4    = 4'd5,
    StT5    = 4'd6,
    StT6    = 4'd7,
    StT7    = 4'd8,
    StHalt  = 4'd15
  } state_e;

  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpLdi  = 5'b00001;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpShl  = 5'b01011;
  localparam logic [4:0] OpAddi = 5'b01100;
  localparam logic [4:0] OpOri  = 5'b01110;
  localparam logic [4:0] OpMul  = 5'b01111;
  localparam logic [4:0] OpDiv  = 5'b10000;
  localparam logic [4:0] OpBr   = 5'b10011;
  localparam logic [4:0] OpJr   = 5'b10100;
  localparam logic [4:0] OpMfhi = 5'b11000;
  localparam logic [4:0] OpMflo = 5'b11001;
  localparam logic [4:0] OpHalt = 5'b11011;

  state_e     state_q, state_d;
  state_e     last_st;
  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = bus.ir[31:27];
  assign unused_ir = ^bus.ir[26:0];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= StReset;
    else     state_q <= state_d;
  end

  // Final execute step of each opcode; nop, halt and unlisted opcodes end in T3.
  always_comb begin
    case (opcode) inside
      OpLd, OpSt:              last_st = StT7;
      OpLdi, [OpAdd:OpOri]:    last_st = StT5;
      OpMul, OpDiv, OpBr:      last_st = StT6;
      default:                 last_st = StT3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset: state_d = StT0;
      StT0:    state_d = StT1;
      StT1:    state_d = StT2;
      StT2:    state_d = StT3;
      StHalt:  state_d = StHalt;
      default: begin
        // stop only matters on the edge that closes the instruction
        if (state_q == last_st) state_d = (bus.stop || opcode == OpHalt) ? StHalt : StT0;
        else                    state_d = state_e'(state_q + 4'd1);
      end
    endcase
  end

  always_comb begin
    bus.PCout = 1'b0; bus.ZHIout = 1'b0; bus.ZLOout = 1'b0; bus.MDRout = 1'b0;
    bus.HIout = 1'b0; bus.LOout = 1'b0; bus.Cout = 1'b0;
    bus.PCen = 1'b0; bus.IRen = 1'b0; bus.MARen = 1'b0; bus.MDRen = 1'b0; bus.Yen = 1'b0;
    bus.ZHIen = 1'b0; bus.ZLOen = 1'b0; bus.HIen = 1'b0; bus.LOen = 1'b0;
    bus.Read = 1'b0; bus.Write = 1'b0;
    bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0; bus.Rin = 1'b0; bus.Rout = 1'b0;
    bus.BAout = 1'b0; bus.ConIn = 1'b0; bus.incPC = 1'b0;
    bus.alu_control = 5'd0;
    bus.run  = (state_q != StReset) && (state_q != StHalt);
    bus.step = state_q;

    unique case (state_q)
      StT0: begin
        bus.PCout = 1'b1; bus.MARen = 1'b1; bus.incPC = 1'b1; bus.ZLOen = 1'b1;
        bus.alu_control = OpAdd;
      end
      StT1: begin bus.ZLOout = 1'b1; bus.PCen = 1'b1; bus.Read = 1'b1; bus.MDRen = 1'b1; end
      StT2: begin bus.MDRout = 1'b1; bus.IRen = 1'b1; end
      StT3: begin
        case (opcode) inside
          OpLd, OpLdi, OpSt:      begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yen = 1'b1; end
          [OpAdd:OpOri]:          begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yen = 1'b1; end
          OpMul, OpDiv:           begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yen = 1'b1; end
          OpBr:                   begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.ConIn = 1'b1; end
          OpJr:                   begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCen = 1'b1; end
          OpMfhi:                 begin bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          OpMflo:                 begin bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          default: ;
        endcase
      end
      StT4: begin
        case (opcode) inside
          OpLd, OpLdi, OpSt: begin bus.Cout = 1'b1; bus.ZLOen = 1'b1; bus.alu_control = OpAdd; end
          [OpAdd:OpShl]: begin
            bus.Grc = 1'b1; bus.Rout = 1'b1; bus.ZLOen = 1'b1; bus.alu_control = opcode;
          end
          [OpAddi:OpOri]: begin bus.Cout = 1'b1; bus.ZLOen = 1'b1; bus.alu_control = opcode; end
          OpMul, OpDiv: begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.ZHIen = 1'b1; bus.ZLOen = 1'b1;
            bus.alu_control = opcode;
          end
          OpBr:    begin bus.PCout = 1'b1; bus.Yen = 1'b1; end
          default: ;
        endcase
      end
      StT5: begin
        case (opcode) inside
          OpLd, OpSt:            begin bus.ZLOout = 1'b1; bus.MARen = 1'b1; end
          OpLdi, [OpAdd:OpOri]:  begin bus.ZLOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          OpMul, OpDiv:          begin bus.ZLOout = 1'b1; bus.LOen = 1'b1; end
          OpBr: begin bus.Cout = 1'b1; bus.ZLOen = 1'b1; bus.alu_control = OpAdd; end
          default: ;
        endcase
      end
      StT6: begin
        case (opcode) inside
          OpLd:         begin bus.Read = 1'b1; bus.MDRen = 1'b1; end
          OpSt:         begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRen = 1'b1; end
          OpMul, OpDiv: begin bus.ZHIout = 1'b1; bus.HIen = 1'b1; end
          OpBr:         begin bus.ZLOout = bus.con_ff; bus.PCen = bus.con_ff; end
          default: ;
        endcase
      end
      StT7: begin
        case (opcode) inside
          OpLd:    begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          OpSt:    bus.Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mini_src_control_unit.sv
module tb_mini_src_control_unit;

  typedef logic [30:0] word_t;  // {26 strobes, alu_control}

  typedef struct {
    logic [31:0] ir;
    logic        cf;
    logic        stp;
    int          cpi;
  } vec_t;

  localparam logic [3:0] StepT0   = 4'd1;
  localparam logic [3:0] StepHalt = 4'd15;
  localparam logic [4:0] AluAdd   = 5'b00011;

  localparam logic [25:0] MPCout  = 26'd1 << 25;
  localparam logic [25:0] MZHIout = 26'd1 << 24;
  localparam logic [25:0] MZLOout = 26'd1 << 23;
  localparam logic [25:0] MMDRout = 26'd1 << 22;
  localparam logic [25:0] MHIout  = 26'd1 << 21;
  localparam logic [25:0] MLOout  = 26'd1 << 20;
  localparam logic [25:0] MCout   = 26'd1 << 19;
  localparam logic [25:0] MPCen   = 26'd1 << 18;
  localparam logic [25:0] MIRen   = 26'd1 << 17;
  localparam logic [25:0] MMARen  = 26'd1 << 16;
  localparam logic [25:0] MMDRen  = 26'd1 << 15;
  localparam logic [25:0] MYen    = 26'd1 << 14;
  localparam logic [25:0] MZHIen  = 26'd1 << 13;
  localparam logic [25:0] MZLOen  = 26'd1 << 12;
  localparam logic [25:0] MHIen   = 26'd1 << 11;
  localparam logic [25:0] MLOen   = 26'd1 << 10;
  localparam logic [25:0] MRead   = 26'd1 << 9;
  localparam logic [25:0] MWrite  = 26'd1 << 8;
  localparam logic [25:0] MGra    = 26'd1 << 7;
  localparam logic [25:0] MGrb    = 26'd1 << 6;
  localparam logic [25:0] MGrc    = 26'd1 << 5;
  localparam logic [25:0] MRin    = 26'd1 << 4;
  localparam logic [25:0] MRout   = 26'd1 << 3;
  localparam logic [25:0] MBAout  = 26'd1 << 2;
  localparam logic [25:0] MConIn  = 26'd1 << 1;
  localparam logic [25:0] MIncPC  = 26'd1;

  logic clk;
  logic clr;
  int   vectors;
  int   miscompares;
  word_t prog[$];
  vec_t  tbl[$];

  mini_src_control_unit_if bus ();

  mini_src_control_unit dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] observe();
    return {bus.PCout, bus.ZHIout, bus.ZLOout, bus.MDRout, bus.HIout, bus.LOout, bus.Cout,
            bus.PCen, bus.IRen, bus.MARen, bus.MDRen, bus.Yen, bus.ZHIen, bus.ZLOen,
            bus.HIen, bus.LOen, bus.Read, bus.Write, bus.Gra, bus.Grb, bus.Grc, bus.Rin,
            bus.Rout, bus.BAout, bus.ConIn, bus.incPC, bus.alu_control, bus.run, bus.step};
  endfunction

  function automatic word_t w(input logic [25:0] s, input logic [4:0] a);
    return {s, a};
  endfunction

  // Reference microprogram: the strobe set of every step, fetch included.
  function automatic void build_program(input logic [4:0] op, input logic cf);
    int unsigned o;
    o = op;
    prog.delete();
    prog.push_back(w(MPCout | MMARen | MIncPC | MZLOen, AluAdd));
    prog.push_back(w(MZLOout | MPCen | MRead | MMDRen, 5'd0));
    prog.push_back(w(MMDRout | MIRen, 5'd0));
    if (o <= 2) begin
      prog.push_back(w(MGrb | MBAout | MYen, 5'd0));
      prog.push_back(w(MCout | MZLOen, AluAdd));
      if (o == 1) prog.push_back(w(MZLOout | MGra | MRin, 5'd0));
      else begin
        prog.push_back(w(MZLOout | MMARen, 5'd0));
        if (o == 0) begin
          prog.push_back(w(MRead | MMDRen, 5'd0));
          prog.push_back(w(MMDRout | MGra | MRin, 5'd0));
        end else begin
          prog.push_back(w(MGra | MRout | MMDRen, 5'd0));
          prog.push_back(w(MWrite, 5'd0));
        end
      end
    end else if (o <= 14) begin
      prog.push_back(w(MGrb | MRout | MYen, 5'd0));
      prog.push_back(w(((o <= 11) ? (MGrc | MRout) : MCout) | MZLOen, op));
      prog.push_back(w(MZLOout | MGra | MRin, 5'd0));
    end else if (o <= 16) begin
      prog.push_back(w(MGra | MRout | MYen, 5'd0));
      prog.push_back(w(MGrb | MRout | MZHIen | MZLOen, op));
      prog.push_back(w(MZLOout | MLOen, 5'd0));
      prog.push_back(w(MZHIout | MHIen, 5'd0));
    end else if (o == 19) begin
      prog.push_back(w(MGra | MRout | MConIn, 5'd0));
      prog.push_back(w(MPCout | MYen, 5'd0));
      prog.push_back(w(MCout | MZLOen, AluAdd));
      prog.push_back(w(cf ? (MZLOout | MPCen) : 26'd0, 5'd0));
    end else if (o == 20) prog.push_back(w(MGra | MRout | MPCen, 5'd0));
    else if (o == 24)     prog.push_back(w(MHIout | MGra | MRin, 5'd0));
    else if (o == 25)     prog.push_back(w(MLOout | MGra | MRin, 5'd0));
    else                  prog.push_back(w(26'd0, 5'd0));
  endfunction

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Entered one time unit after the edge that starts T0.
  task automatic run_instr(input string name, input logic [31:0] instr, input logic cf,
                           input logic stp, output int cycles);
    logic       halts;
    logic [4:0] op;
    op = instr[31:27];
    build_program(op, cf);
    halts = stp || (op == 5'b11011);
    cycles = 0;
    do begin
      bus.ir     = (cycles < 3) ? $urandom : instr;
      bus.con_ff = (cycles == 6) ? cf : 1'($urandom);
      bus.stop   = (cycles == int'(prog.size()) - 1) ? stp : 1'($urandom);
      #1;
      if (cycles < int'(prog.size()))
        check(name, observe(), {prog[cycles], 1'b1, 4'(cycles + 1)});
      else begin
        vectors++;
        miscompares++;
        $display("FAIL %s overrun: got step %0d, expected end after %0d steps",
                 name, bus.step, prog.size());
      end
      @(posedge clk);
      #1;
      cycles++;
    end while (bus.step != StepT0 && bus.step != StepHalt && cycles < 12);
    if (halts) check({name, " end"}, observe(), {31'd0, 1'b0, StepHalt});
    else       check({name, " end"}, observe(), {prog[0], 1'b1, StepT0});
  endtask

  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) begin
      bus.ir = $urandom;
      bus.con_ff = 1'($urandom);
      bus.stop = 1'($urandom);
      #1;
      check("halt hold", observe(), {31'd0, 1'b0, StepHalt});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.stop = 1'b0;
    clr = 1'b1;
    #1;
    check("reset", observe(), {31'd0, 1'b0, 4'd0});
    repeat (2) @(posedge clk);
    #1;
    check("reset held", observe(), {31'd0, 1'b0, 4'd0});
    clr = 1'b0;
    @(posedge clk);
    #1;
    check("reset release", observe(),
          {w(MPCout | MMARen | MIncPC | MZLOen, AluAdd), 1'b1, StepT0});
  endtask

  initial begin
    int cyc;
    logic [4:0] op;
    logic stp;
    clk = 1'b0;
    clr = 1'b1;
    vectors = 0;
    miscompares = 0;
    bus.stop = 1'b0;
    bus.ir = 32'd0;
    bus.con_ff = 1'b0;
    #2;
    do_reset();

    // Abort an add in T5 with a two-cycle clear.
    bus.ir = 32'h1891_8000;
    repeat (5) begin @(posedge clk); #1; end
    check("pre-abort T5", observe(), {w(MZLOout | MGra | MRin, 5'd0), 1'b1, 4'd6});
    do_reset();

    tbl.push_back('{32'h1891_8000, 1'b0, 1'b0, 6});                    // add r1,r2,r3
    tbl.push_back('{{5'b00000, 4'd1, 4'd2, 19'h55}, 1'b0, 1'b0, 8});   // ld r1,0x55(r2)
    tbl.push_back('{{5'b00001, 27'h123}, 1'b0, 1'b0, 6});
    tbl.push_back('{{5'b00010, 27'h456}, 1'b1, 1'b0, 8});
    tbl.push_back('{{5'b00100, 27'h0}, 1'b0, 1'b0, 6});
    tbl.push_back('{{5'b01011, 27'h7}, 1'b0, 1'b0, 6});
    tbl.push_back('{{5'b01100, 27'h9}, 1'b0, 1'b0, 6});
    tbl.push_back('{{5'b01110, 27'h1}, 1'b1, 1'b0, 6});
    tbl.push_back('{{5'b01111, 27'h2}, 1'b0, 1'b0, 7});
    tbl.push_back('{{5'b10000, 27'h3}, 1'b0, 1'b0, 7});
    tbl.push_back('{{5'b10011, 27'h4}, 1'b0, 1'b0, 7});
    tbl.push_back('{{5'b10011, 27'h4}, 1'b1, 1'b0, 7});
    tbl.push_back('{{5'b10100, 27'h5}, 1'b0, 1'b0, 4});
    tbl.push_back('{{5'b11000, 27'h6}, 1'b0, 1'b0, 4});
    tbl.push_back('{{5'b11001, 27'h6}, 1'b0, 1'b0, 4});
    tbl.push_back('{{5'b11010, 27'h0}, 1'b0, 1'b0, 4});
    tbl.push_back('{{5'b10001, 27'h0}, 1'b1, 1'b0, 4});
    tbl.push_back('{{5'b11111, 27'h0}, 1'b0, 1'b0, 4});
    tbl.push_back('{32'h1891_8000, 1'b0, 1'b1, 6});                    // add with stop
    tbl.push_back('{{5'b11011, 27'h0}, 1'b0, 1'b0, 4});                // halt

    foreach (tbl[i]) begin
      string nm;
      nm = $sformatf("vec%0d op%0d", i, tbl[i].ir[31:27]);
      run_instr(nm, tbl[i].ir, tbl[i].cf, tbl[i].stp, cyc);
      check_int({nm, " cpi"}, cyc, tbl[i].cpi);
      if (bus.step == StepHalt) begin
        halt_hold(12);
        do_reset();
      end
    end

    for (int n = 0; n < 150; n++) begin
      op  = 5'($urandom_range(0, 31));
      stp = ($urandom_range(0, 19) == 0);
      run_instr($sformatf("rand%0d op%0d", n, op), {op, 27'($urandom)}, 1'($urandom), stp, cyc);
      if (bus.step == StepHalt || stp || op == 5'b11011) begin
        halt_hold(3);
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
